// File: rtl/calc16_pkg.sv
// Shared constants for the calc16 tile: command codes, ALU op codes and
// the bit positions of the status flags on uio_out.
package calc16_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_LDAL  = 3'd1,
        CMD_LDAH  = 3'd2,
        CMD_LDBL  = 3'd3,
        CMD_LDBH  = 3'd4,
        CMD_EXEC  = 3'd5,
        CMD_SELLO = 3'd6,
        CMD_SELHI = 3'd7
    } cmd_e;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SHL = 3'd5,
        OP_SHR = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    localparam int FLAG_VALID = 7;
    localparam int FLAG_V     = 6;
    localparam int FLAG_C     = 5;
    localparam int FLAG_Z     = 4;

    localparam logic [7:0] UIO_OE_VAL = 8'hF0;

endpackage

// File: rtl/calc16_alu.sv
// Combinational 16-bit ALU: eight operations with carry/borrow/shift-out
// and two's-complement overflow outputs. Zero flag is derived by the caller.
module calc16_alu
    import calc16_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [2:0]        op_i,
    output logic [DATA_W-1:0] result_o,
    output logic              c_o,
    output logic              v_o
);

    logic signed [DATA_W-1:0] a_s;
    logic signed [DATA_W-1:0] b_s;
    logic [DATA_W:0]          sum;
    logic [DATA_W:0]          diff;
    logic [DATA_W:0]          shl;
    logic [DATA_W:0]          shr;
    logic [2*DATA_W-1:0]      prod;

    assign a_s  = a_i;
    assign b_s  = b_i;
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};
    // One guard bit above (SHL) or below (SHR) catches the last bit shifted out.
    assign shl  = {1'b0, a_i} << b_i[3:0];
    assign shr  = {a_i, 1'b0} >> b_i[3:0];
    assign prod = {{DATA_W{1'b0}}, a_i} * {{DATA_W{1'b0}}, b_i};

    always_comb begin
        result_o = '0;
        c_o      = 1'b0;
        v_o      = 1'b0;
        case (op_e'(op_i))
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                c_o      = sum[DATA_W];
                v_o      = (a_s[DATA_W-1] == b_s[DATA_W-1]) &&
                           (sum[DATA_W-1] != a_s[DATA_W-1]);
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                c_o      = diff[DATA_W];
                v_o      = (a_s[DATA_W-1] != b_s[DATA_W-1]) &&
                           (diff[DATA_W-1] != a_s[DATA_W-1]);
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SHL: begin
                result_o = shl[DATA_W-1:0];
                c_o      = shl[DATA_W];
            end
            OP_SHR: begin
                result_o = shr[DATA_W:1];
                c_o      = shr[0];
            end
            OP_MUL: begin
                result_o = prod[DATA_W-1:0];
                c_o      = |prod[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/calc16_muehlbb.sv
// TinyTapeout user tile: byte-loaded 16-bit operands, strobe-edge command
// decode, registered ALU result and flags, byte-selectable result output.
module calc16_muehlbb
    import calc16_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] r_q, r_d;
    logic              z_q, z_d;
    logic              c_q, c_d;
    logic              v_q, v_d;
    logic              valid_q, valid_d;
    logic              sel_hi_q, sel_hi_d;
    logic              strobe_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_c;
    logic              alu_v;
    logic              fire;
    cmd_e              cmd;
    logic              unused_uio;

    assign unused_uio = &{1'b0, uio_in[7:4]};

    calc16_alu u_alu (
        .a_i      (a_q),
        .b_i      (b_q),
        .op_i     (ui_in[2:0]),
        .result_o (alu_res),
        .c_o      (alu_c),
        .v_o      (alu_v)
    );

    // strobe_q resets high so a strobe held across reset release never fires.
    assign fire = ena && uio_in[3] && !strobe_q;
    assign cmd  = cmd_e'(uio_in[2:0]);

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        r_d      = r_q;
        z_d      = z_q;
        c_d      = c_q;
        v_d      = v_q;
        valid_d  = valid_q;
        sel_hi_d = sel_hi_q;
        if (fire) begin
            case (cmd)
                CMD_LDAL: begin a_d[7:0]  = ui_in; valid_d = 1'b0; end
                CMD_LDAH: begin a_d[15:8] = ui_in; valid_d = 1'b0; end
                CMD_LDBL: begin b_d[7:0]  = ui_in; valid_d = 1'b0; end
                CMD_LDBH: begin b_d[15:8] = ui_in; valid_d = 1'b0; end
                CMD_EXEC: begin
                    r_d     = alu_res;
                    z_d     = (alu_res == '0);
                    c_d     = alu_c;
                    v_d     = alu_v;
                    valid_d = 1'b1;
                end
                CMD_SELLO: sel_hi_d = 1'b0;
                CMD_SELHI: sel_hi_d = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            b_q      <= '0;
            r_q      <= '0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            valid_q  <= 1'b0;
            sel_hi_q <= 1'b0;
            strobe_q <= 1'b1;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            r_q      <= r_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            valid_q  <= valid_d;
            sel_hi_q <= sel_hi_d;
            strobe_q <= uio_in[3];
        end
    end

    assign uo_out = sel_hi_q ? r_q[15:8] : r_q[7:0];

    always_comb begin
        uio_out             = 8'h00;
        uio_out[FLAG_VALID] = valid_q;
        uio_out[FLAG_V]     = v_q;
        uio_out[FLAG_C]     = c_q;
        uio_out[FLAG_Z]     = z_q;
    end

    assign uio_oe = UIO_OE_VAL;

endmodule

// File: tb/tb_calc16_muehlbb.sv
// Self-checking bench for calc16_muehlbb: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_calc16_muehlbb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int errors = 0;
    int checks = 0;
    bit run    = 1'b0;

    calc16_muehlbb dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference ALU from plain integer arithmetic; returns {V, C, Z, R}.
    function automatic logic [18:0] alu_ref(input int unsigned a, input int unsigned b,
                                            input int op);
        int unsigned r;
        longint unsigned p;
        int sa, sb, s, sh;
        bit c, v;
        r  = 0; c = 0; v = 0;
        sa = (a > 32767) ? int'(a) - 65536 : int'(a);
        sb = (b > 32767) ? int'(b) - 65536 : int'(b);
        sh = int'(b & 15);
        case (op)
            0: begin r = a + b; c = (r > 65535); s = sa + sb; v = (s > 32767) || (s < -32768); end
            1: begin r = (a - b) & 32'hFFFF; c = (a < b); s = sa - sb; v = (s > 32767) || (s < -32768); end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: begin r = a << sh; c = (sh != 0) ? (((a >> (16 - sh)) & 1) != 0) : 1'b0; end
            6: begin r = a >> sh; c = (sh != 0) ? (((a >> (sh - 1)) & 1) != 0) : 1'b0; end
            default: begin p = 64'(a) * 64'(b); r = 32'(p & 64'hFFFF); c = (p > 65535); end
        endcase
        r = r & 32'hFFFF;
        return {v, c, (r == 0), r[15:0]};
    endfunction

    logic [15:0] m_a, m_b, m_r;
    logic        m_z, m_c, m_v, m_valid, m_sel, m_sq;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_a <= '0; m_b <= '0; m_r <= '0;
            m_z <= 0; m_c <= 0; m_v <= 0; m_valid <= 0; m_sel <= 0; m_sq <= 1;
        end else begin
            m_sq <= uio_in[3];
            if (ena && uio_in[3] && !m_sq) begin
                case (uio_in[2:0])
                    3'd1: begin m_a[7:0]  <= ui_in; m_valid <= 0; end
                    3'd2: begin m_a[15:8] <= ui_in; m_valid <= 0; end
                    3'd3: begin m_b[7:0]  <= ui_in; m_valid <= 0; end
                    3'd4: begin m_b[15:8] <= ui_in; m_valid <= 0; end
                    3'd5: begin
                        {m_v, m_c, m_z, m_r} <= alu_ref(m_a, m_b, int'(ui_in[2:0]));
                        m_valid <= 1;
                    end
                    3'd6: m_sel <= 0;
                    3'd7: m_sel <= 1;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            check("model_uo_out", uo_out, m_sel ? m_r[15:8] : m_r[7:0]);
            check("model_uio_out", uio_out, {m_valid, m_v, m_c, m_z, 4'b0000});
            check("model_uio_oe", uio_oe, 8'hF0);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk); #1;
            uio_in[3] = 1'b0;
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic [7:0] d);
        @(negedge clk); #1;
        ui_in  = d;
        uio_in = {4'h0, 1'b1, c};
        @(negedge clk); #1;
        uio_in[3] = 1'b0;
    endtask

    task automatic ld(input logic [15:0] a, input logic [15:0] b);
        cmd(3'd1, a[7:0]);
        cmd(3'd2, a[15:8]);
        cmd(3'd3, b[7:0]);
        cmd(3'd4, b[15:8]);
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'hAA;
        uio_in = 8'h09;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        rst_n = 1'b1;
        run   = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        check("held_strobe_uo", uo_out, 8'h00);
        check("held_strobe_uio", uio_out, 8'h00);
        check("uio_oe_const", uio_oe, 8'hF0);
        idle(1);

        ld(16'hFFFF, 16'h0001);
        cmd(3'd5, 8'd0);
        check("add_uio", uio_out, 8'hB0);
        check("add_uo", uo_out, 8'h00);
        cmd(3'd7, 8'd0);
        check("add_uo_hi", uo_out, 8'h00);

        ld(16'h8000, 16'h0001);
        cmd(3'd5, 8'd1);
        check("sub_uio", uio_out, 8'hC0);
        cmd(3'd6, 8'd0);
        check("sub_uo_lo", uo_out, 8'hFF);
        cmd(3'd7, 8'd0);
        check("sub_uo_hi", uo_out, 8'h7F);
        cmd(3'd1, 8'h12);
        check("ldal_clears_valid", uio_out, 8'h40);
        check("ldal_keeps_r", uo_out, 8'h7F);

        ld(16'h8001, 16'h0001);
        cmd(3'd5, 8'd5);
        check("shl_uio", uio_out, 8'hA0);
        check("shl_uo_hi", uo_out, 8'h00);
        cmd(3'd6, 8'd0);
        check("shl_uo_lo", uo_out, 8'h02);
        cmd(3'd5, 8'd6);
        check("shr_uio", uio_out, 8'hA0);
        check("shr_uo_lo", uo_out, 8'h00);
        cmd(3'd7, 8'd0);
        check("shr_uo_hi", uo_out, 8'h40);

        ld(16'h0100, 16'h0100);
        cmd(3'd5, 8'd7);
        check("mul_ovf_uio", uio_out, 8'hB0);
        check("mul_ovf_uo", uo_out, 8'h00);
        ld(16'h0012, 16'h0034);
        cmd(3'd5, 8'd7);
        check("mul_uio", uio_out, 8'h80);
        check("mul_uo_hi", uo_out, 8'h03);
        cmd(3'd6, 8'd0);
        check("mul_uo_lo", uo_out, 8'hA8);
        cmd(3'd7, 8'd0);

        ena = 1'b0;
        cmd(3'd1, 8'h55);
        cmd(3'd5, 8'd0);
        cmd(3'd6, 8'd0);
        check("ena0_uo", uo_out, 8'h03);
        check("ena0_uio", uio_out, 8'h80);
        ena = 1'b1;
        idle(1);
        cmd(3'd1, 8'h77);
        check("ldal_after_ena", uio_out, 8'h00);
        cmd(3'd2, 8'h66);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_uo", uo_out, 8'h00);
        check("async_rst_uio", uio_out, 8'h00);
        #2 rst_n = 1'b1;
        idle(2);
        cmd(3'd5, 8'd0);
        check("post_rst_add_uio", uio_out, 8'h90);
        check("post_rst_add_uo", uo_out, 8'h00);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk); #1;
            ena    = ($urandom_range(0, 9) != 0);
            ui_in  = 8'($urandom);
            uio_in = {4'($urandom), 1'($urandom_range(0, 1)), 3'($urandom)};
            if ($urandom_range(0, 299) == 0) begin
                #1 rst_n = 1'b0;
                #1 rst_n = 1'b1;
            end
        end
        idle(3);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/calc16_muehlbb.md
Name: calc16_muehlbb

Overview:
- 16-bit integer calculator wrapped in the standard TinyTapeout user-tile pin interface; it is the top-level user module of the tile.
- Two 16-bit operands (A, B) are loaded byte-wise over ui_in under a 3-bit command plus strobe on uio_in.
- An 8-function ALU result is registered.
- The selected result byte appears on uo_out; status flags appear on uio_out[7:4].

Parameters:
- none (width fixed at 16)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- ena  in  1  tile enable; when 0, commands are ignored and state holds
- ui_in  in  8  data byte for loads; op code in ui_in[2:0] on execute
- uio_in  in  8  [2:0] cmd, [3] strobe, [7:4] unused
- uo_out  out  8  selected result byte
- uio_out  out  8  [7] valid, [6] V, [5] C, [4] Z, [3:0] driven 0
- uio_oe  out  8  constant 8'hF0

Behaviour:
- Registers: A[15:0], B[15:0], R[15:0], Z, C, V, valid, sel_hi, strobe_q.
- Reset: A=B=R=0; Z=C=V=valid=0; sel_hi=0 (uo_out=R[7:0]=0); strobe_q=1.
  - strobe_q resets to 1 so a strobe already held high at reset release does not fire.
- Strobe edge: a command fires on the clock edge where ena=1, uio_in[3]=1 and strobe_q=0.
  - strobe_q <= uio_in[3] every cycle, regardless of ena.
  - A held-high strobe fires exactly once.
  - Effects are visible on outputs immediately after the firing edge (1-cycle latency).
- Commands (cmd = uio_in[2:0] at the firing edge):
  - 0 NOP
  - 1 A[7:0] <= ui_in
  - 2 A[15:8] <= ui_in
  - 3 B[7:0] <= ui_in
  - 4 B[15:8] <= ui_in
  - 5 EXEC: R, Z, C, V <= ALU(A, B, ui_in[2:0]); valid <= 1
  - 6 sel_hi <= 0
  - 7 sel_hi <= 1
- Loads 1-4 clear valid. R and the flags keep their old values until the next EXEC.
- uo_out = sel_hi ? R[15:8] : R[7:0] (combinational mux from registers).
- ALU ops (ui_in[2:0]):
  - 0 ADD A+B: C = carry out; V = signed overflow.
  - 1 SUB A-B: C = borrow (A<B unsigned); V = signed overflow.
  - 2 AND, 3 OR, 4 XOR: C = V = 0.
  - 5 SHL A<<B[3:0]: C = last bit shifted out (0 if shift 0); V = 0.
  - 6 SHR logical A>>B[3:0]: C = last bit shifted out (0 if shift 0); V = 0.
  - 7 MUL low 16 of A*B: C = 1 if upper 16 bits of the 32-bit product are nonzero; V = 0.
  - Z = (result == 16'h0000) for every op.
- B[15:4] is ignored for shifts.
- Operands are treated as unsigned except for the V computation (two's complement).
- Asynchronous reset mid-sequence clears all registers immediately, including partially loaded operands.
- uio_oe is constant. uio_out[3:0] = 0 always.

Decomposition:
- Package calc16_pkg holds:
  - cmd constants: CMD_NOP, CMD_LDAL, CMD_LDAH, CMD_LDBL, CMD_LDBH, CMD_EXEC, CMD_SELLO, CMD_SELHI
  - op constants: OP_ADD … OP_MUL
  - flag bit positions
- One combinational sub-module, calc16_alu: inputs a, b, op; outputs result, c, v.
  - Z is derived in the top level.
- The top level holds the registers, strobe edge detect and output mux.

Test Plan:
- Reset with strobe held high, release, hold strobe high 5 cycles -> no command fires; uo_out=0x00, uio_out=0x00, uio_oe=0xF0.
- Load A=0xFFFF, B=0x0001, EXEC ADD -> R=0x0000; Z=1, C=1, V=0, valid=1; after CMD 7, uo_out=0x00.
- A=0x8000, B=0x0001, EXEC SUB -> R=0x7FFF; V=1, C=0, Z=0.
  - uo_out=0xFF with sel low, 0x7F after CMD 7.
  - A subsequent LDAL clears valid while R stays 0x7FFF.
- A=0x8001, B=0x0001, EXEC SHL -> R=0x0002, C=1. EXEC SHR with B=0x0001 -> R=0x4000, C=1.
- A=0x0100, B=0x0100, EXEC MUL -> R=0x0000, Z=1, C=1. A=0x0012, B=0x0034 -> R=0x03A8, C=0.
- ena=0 with strobe edges, then assert rst_n low mid-load -> no state change while ena=0; reset clears A, B, R and flags asynchronously.
